// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel divider, line/frame counters, sync and
// active-video decode, plus line/frame start markers.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic       draw,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_ce,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit decode thresholds so a 1024-wide active region cannot truncate
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 1");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             draw_q, draw_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  logic             pix_ce_w;
  logic             run_d;
  logic             start;
  logic             line_wrap;
  logic             frame_wrap;
  logic [10:0]      h_ext;
  logic [10:0]      v_ext;

  assign pix_ce_w = (state_q == S_RUN) && (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    hcount_d   = hcount_q;
    vcount_d   = vcount_q;
    start      = 1'b0;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        hcount_d  = '0;
        vcount_d  = '0;
        if (enable) begin
          state_d = S_RUN;
          start   = 1'b1;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_d   = S_IDLE;
          div_cnt_d = '0;
          hcount_d  = '0;
          vcount_d  = '0;
        end else if (pix_ce_w) begin
          div_cnt_d = '0;
          if (hcount_q == H_LAST) begin
            hcount_d  = '0;
            line_wrap = 1'b1;
            if (vcount_q == V_LAST) begin
              vcount_d   = '0;
              frame_wrap = 1'b1;
            end else begin
              vcount_d = vcount_q + 10'd1;
            end
          end else begin
            hcount_d = hcount_q + 10'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        div_cnt_d = '0;
        hcount_d  = '0;
        vcount_d  = '0;
      end
    endcase

    // Decode from next-state counters so every marker lines up with posx/posy
    run_d  = (state_d == S_RUN);
    h_ext  = {1'b0, hcount_d};
    v_ext  = {1'b0, vcount_d};

    draw_d  = run_d && (h_ext < H_VIS) && (v_ext < V_VIS);
    hsync_d = (run_d && (h_ext >= HS_FIRST) && (h_ext <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (run_d && (v_ext >= VS_FIRST) && (v_ext <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;

    line_start_d  = start | line_wrap;
    frame_start_d = start | frame_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      div_cnt_q     <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      draw_q        <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      draw_q        <= draw_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign posx        = hcount_q;
  assign posy        = vcount_q;
  assign draw        = draw_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pix_ce      = pix_ce_w;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (default, small 3-clk geometry,
// CLK_DIV=1 active-high sync) against a time-based arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [3];
  logic       en    [3];
  logic [9:0] posx  [3];
  logic [9:0] posy  [3];
  logic       draw  [3];
  logic       hsync [3];
  logic       vsync [3];
  logic       pix_ce[3];
  logic       lstart[3];
  logic       fstart[3];

  int g_hact[3] = '{640, 8, 640};
  int g_hfp [3] = '{16, 2, 16};
  int g_hsy [3] = '{96, 3, 96};
  int g_hbp [3] = '{48, 2, 48};
  int g_vact[3] = '{480, 4, 480};
  int g_vfp [3] = '{10, 1, 10};
  int g_vsy [3] = '{2, 2, 2};
  int g_vbp [3] = '{33, 1, 33};
  int g_div [3] = '{2, 3, 1};
  bit g_pol [3] = '{1'b0, 1'b0, 1'b1};

  vga_timing_gen u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .enable(en[0]), .posx(posx[0]), .posy(posy[0]),
    .draw(draw[0]), .hsync(hsync[0]), .vsync(vsync[0]), .pix_ce(pix_ce[0]),
    .line_start(lstart[0]), .frame_start(fstart[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .CLK_DIV(3)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .enable(en[1]), .posx(posx[1]), .posy(posy[1]),
    .draw(draw[1]), .hsync(hsync[1]), .vsync(vsync[1]), .pix_ce(pix_ce[1]),
    .line_start(lstart[1]), .frame_start(fstart[1])
  );

  vga_timing_gen #(
    .SYNC_POL(1'b1), .CLK_DIV(1)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .enable(en[2]), .posx(posx[2]), .posy(posy[2]),
    .draw(draw[2]), .hsync(hsync[2]), .vsync(vsync[2]), .pix_ce(pix_ce[2]),
    .line_start(lstart[2]), .frame_start(fstart[2])
  );

  // Model: clks elapsed since the start edge; everything else is derived from it
  bit run[3];
  int t  [3];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s[dut%0d] observed=%0d expected=%0d (t=%0d run=%0d)", tag, k, obs, exp, t[k], run[k]);
    end
  endtask

  function automatic int model_x(input int k);
    int ht;
    ht = g_hact[k] + g_hfp[k] + g_hsy[k] + g_hbp[k];
    return run[k] ? (t[k] / g_div[k]) % ht : 0;
  endfunction

  function automatic int model_y(input int k);
    int ht, vt;
    ht = g_hact[k] + g_hfp[k] + g_hsy[k] + g_hbp[k];
    vt = g_vact[k] + g_vfp[k] + g_vsy[k] + g_vbp[k];
    return run[k] ? ((t[k] / g_div[k]) / ht) % vt : 0;
  endfunction

  task automatic check_dut(input int k);
    int  x, y, ht, vt, line_clks;
    logic ed, ehs, evs, ece, els, efs;
    ht = g_hact[k] + g_hfp[k] + g_hsy[k] + g_hbp[k];
    vt = g_vact[k] + g_vfp[k] + g_vsy[k] + g_vbp[k];
    line_clks = ht * g_div[k];
    x = model_x(k);
    y = model_y(k);
    if (!run[k]) begin
      ed = 0; ehs = ~g_pol[k]; evs = ~g_pol[k]; ece = 0; els = 0; efs = 0;
    end else begin
      ed  = (x < g_hact[k]) && (y < g_vact[k]);
      ehs = (x >= g_hact[k] + g_hfp[k] && x < g_hact[k] + g_hfp[k] + g_hsy[k]) ? g_pol[k] : ~g_pol[k];
      evs = (y >= g_vact[k] + g_vfp[k] && y < g_vact[k] + g_vfp[k] + g_vsy[k]) ? g_pol[k] : ~g_pol[k];
      ece = (t[k] % g_div[k]) == g_div[k] - 1;
      els = (t[k] % line_clks) == 0;
      efs = (t[k] % (line_clks * vt)) == 0;
    end
    chk("posx", k, 32'(posx[k]), 32'(x));
    chk("posy", k, 32'(posy[k]), 32'(y));
    chk("draw", k, 32'(draw[k]), 32'(ed));
    chk("hsync", k, 32'(hsync[k]), 32'(ehs));
    chk("vsync", k, 32'(vsync[k]), 32'(evs));
    chk("pix_ce", k, 32'(pix_ce[k]), 32'(ece));
    chk("line_start", k, 32'(lstart[k]), 32'(els));
    chk("frame_start", k, 32'(fstart[k]), 32'(efs));
  endtask

  // One clk: advance the model at the edge, compare all builds on the falling edge
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n[k])   run[k] = 0;
      else if (en[k]) begin
        if (run[k]) t[k]++;
        else begin run[k] = 1; t[k] = 0; end
      end else         run[k] = 0;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_dut(k);
  endtask

  task automatic async_rst(input int k);
    #2 rst_n[k] = 1'b0;
    run[k] = 0;
    #1 check_dut(k);
  endtask

  task automatic count_to_next_ls(input int k, output int n);
    n = 0;
    do begin tick(); n++; end while (!lstart[k] && n < 5000);
  endtask

  task automatic run_to(input int k, input int x, input int y);
    int n;
    n = 0;
    while (!(model_x(k) == x && model_y(k) == y) && n < 20000) begin tick(); n++; end
    chk("reach_pos_bound", k, 32'(n < 20000), 32'd1);
  endtask

  initial begin
    int n, lo;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b1; en[k] = 1'b0; run[k] = 0; t[k] = 0;
    end
    #1;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check_dut(k);
    tick(); tick();
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    repeat (3) tick();

    // Start on every build together
    for (int k = 0; k < 3; k++) en[k] = 1'b1;
    tick();
    chk("start_fs", 0, 32'(fstart[0]), 32'd1);
    chk("start_draw", 0, 32'(draw[0]), 32'd1);
    tick();
    chk("start_fs_1clk", 0, 32'(fstart[0]), 32'd0);
    tick();
    chk("posx_after_2", 0, 32'(posx[0]), 32'd1);

    count_to_next_ls(0, n);
    count_to_next_ls(0, n);
    chk("line_period_div2", 0, 32'(n), 32'd1600);
    count_to_next_ls(2, n);
    chk("line_period_div1", 2, 32'(n), 32'd800);

    lo = 0;
    n = 0;
    do begin tick(); n++; if (hsync[0] == 1'b0) lo++; end while (!lstart[0] && n < 5000);
    chk("hsync_low_clks", 0, 32'(lo), 32'd192);

    n = 0;
    do begin tick(); n++; end while (!fstart[1] && n < 5000);
    n = 0;
    do begin tick(); n++; end while (!fstart[1] && n < 5000);
    chk("frame_period_small", 1, 32'(n), 32'd360);

    // Enable drop while hsync is asserted
    run_to(0, 700, 4);
    chk("pre_drop_hsync", 0, 32'(hsync[0]), 32'd0);
    en[0] = 1'b0;
    tick();
    chk("drop_hsync_idle", 0, 32'(hsync[0]), 32'd1);
    chk("drop_posx_idle", 0, 32'(posx[0]), 32'd0);
    en[0] = 1'b1;
    tick();
    chk("restart_fs", 0, 32'(fstart[0]), 32'd1);

    // Async reset mid-line, then hold idle after release until enable
    run_to(0, 300, 1);
    async_rst(0);
    chk("rst_posx_now", 0, 32'(posx[0]), 32'd0);
    tick();
    rst_n[0] = 1'b1;
    en[0] = 1'b0;
    repeat (5) tick();
    en[0] = 1'b1;
    tick();

    // Random enable toggles and reset pulses, all builds
    for (int i = 0; i < 15000; i++) begin
      int pick;
      tick();
      for (int k = 0; k < 3; k++) begin
        if (!rst_n[k]) rst_n[k] = 1'b1;
        if (en[k] && $urandom_range(0, 1999) == 0) en[k] = 1'b0;
        else if (!en[k] && $urandom_range(0, 19) == 0) en[k] = 1'b1;
      end
      if ($urandom_range(0, 2999) == 0) begin
        pick = int'($urandom_range(0, 2));
        async_rst(pick);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
